// File: rtl/execute_out_buffer_if.sv
// execute_out_buffer_if
// Bundles the execute-result push side and the buffered head/handshake side
// of execute_out_buffer into one interface.
//   master : producer/consumer view (drives push bundle and out_ready)
//   slave  : buffer view (drives q_* fields, out_valid, stall, count,
//            overflow, drop_count)
interface execute_out_buffer_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // push side
  logic              enable_execute;
  logic [DATA_W-1:0] aluout;
  logic [DATA_W-1:0] pcout;
  logic [DATA_W-1:0] IR_Exec;
  logic [DATA_W-1:0] M_Data;
  logic [1:0]        W_Control_out;
  logic              Mem_Control_out;
  logic [2:0]        NZP;
  logic [REG_W-1:0]  sr1;
  logic [REG_W-1:0]  sr2;
  logic [REG_W-1:0]  dr;

  // head side
  logic [DATA_W-1:0] q_aluout;
  logic [DATA_W-1:0] q_pcout;
  logic [DATA_W-1:0] q_IR_Exec;
  logic [DATA_W-1:0] q_M_Data;
  logic [1:0]        q_W_Control_out;
  logic              q_Mem_Control_out;
  logic [2:0]        q_NZP;
  logic [REG_W-1:0]  q_sr1;
  logic [REG_W-1:0]  q_sr2;
  logic [REG_W-1:0]  q_dr;
  logic              out_valid;
  logic              out_ready;

  // status
  logic              stall;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [7:0]        drop_count;

  modport master (
    output enable_execute, aluout, pcout, IR_Exec, M_Data, W_Control_out,
           Mem_Control_out, NZP, sr1, sr2, dr, out_ready,
    input  q_aluout, q_pcout, q_IR_Exec, q_M_Data, q_W_Control_out,
           q_Mem_Control_out, q_NZP, q_sr1, q_sr2, q_dr, out_valid,
           stall, count, overflow, drop_count
  );

  modport slave (
    input  enable_execute, aluout, pcout, IR_Exec, M_Data, W_Control_out,
           Mem_Control_out, NZP, sr1, sr2, dr, out_ready,
    output q_aluout, q_pcout, q_IR_Exec, q_M_Data, q_W_Control_out,
           q_Mem_Control_out, q_NZP, q_sr1, q_sr2, q_dr, out_valid,
           stall, count, overflow, drop_count
  );
endinterface

// File: rtl/execute_out_buffer.sv
// execute_out_buffer
// Capture FIFO for the LC3 execute-stage result bundle. Every cycle
// enable_execute is high the bundle is pushed (if there is room, or a pop
// frees a slot in the same cycle); the oldest entry is offered on q_* with a
// valid/ready handshake. Pushes arriving while full with no pop are dropped
// and accounted in the sticky overflow flag and saturating drop_count.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high; empties the buffer and clears status
//   bus   - execute_out_buffer_if.slave (push bundle, head bundle,
//           out_valid/out_ready, stall, count, overflow, drop_count)
module execute_out_buffer #(
  parameter int DATA_W       = 16,
  parameter int REG_W        = 3,
  parameter int DEPTH        = 4,
  parameter int DROP_ON_FULL = 0
) (
  input logic                  clock,
  input logic                  reset,
  execute_out_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = 4 * DATA_W + 2 + 1 + 3 + 3 * REG_W;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    drop_count;

  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [BW-1:0] in_bundle;
  logic [BW-1:0] head;

  assign in_bundle = {bus.aluout, bus.pcout, bus.IR_Exec, bus.M_Data,
                      bus.W_Control_out, bus.Mem_Control_out, bus.NZP,
                      bus.sr1, bus.sr2, bus.dr};

  assign full = (count == FULL_COUNT);
  assign pop  = (count != {CW{1'b0}}) && bus.out_ready;
  // A pop frees the slot this same edge, so a full buffer still accepts.
  assign push = bus.enable_execute && (!full || pop);
  assign drop = bus.enable_execute && full && !pop;

  // Storage, pointers, occupancy and drop accounting.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      count      <= {CW{1'b0}};
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_bundle;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

  // Head is forced to zero when empty so stale storage never leaks out.
  always_comb begin
    head = {BW{1'b0}};
    if (count != {CW{1'b0}}) begin
      head = mem[rd_ptr];
    end else begin
      head = {BW{1'b0}};
    end
  end

  assign {bus.q_aluout, bus.q_pcout, bus.q_IR_Exec, bus.q_M_Data,
          bus.q_W_Control_out, bus.q_Mem_Control_out, bus.q_NZP,
          bus.q_sr1, bus.q_sr2, bus.q_dr} = head;

  assign bus.out_valid  = (count != {CW{1'b0}});
  // Derived only from registered count: a popping cycle still shows stall.
  assign bus.stall      = (DROP_ON_FULL == 0) ? full : 1'b0;
  assign bus.count      = count;
  assign bus.overflow   = overflow;
  assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_execute_out_buffer.sv
// Self-checking bench for execute_out_buffer. Two instances (stall mode and
// drop mode) receive identical stimulus; a queue-based reference model
// predicts the contents, occupancy and drop accounting for both.
module tb_execute_out_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] md;
    logic [1:0]  wc;
    logic        mc;
    logic [2:0]  nzp;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [2:0]  d;
  } bundle_t;

  logic    clock;
  logic    reset;
  logic    enable;
  logic    out_ready;
  bundle_t in_b;
  bundle_t head0;
  bundle_t head1;

  bundle_t mq[$];
  bit      m_ovf;
  int      m_drops;
  int      n_checks;
  int      n_fail;

  execute_out_buffer_if #(.DATA_W(16), .REG_W(3), .DEPTH(DEPTH)) bus0 ();
  execute_out_buffer_if #(.DATA_W(16), .REG_W(3), .DEPTH(DEPTH)) bus1 ();

  execute_out_buffer #(.DATA_W(16), .REG_W(3), .DEPTH(DEPTH), .DROP_ON_FULL(0))
    u_stall (.clock(clock), .reset(reset), .bus(bus0));
  execute_out_buffer #(.DATA_W(16), .REG_W(3), .DEPTH(DEPTH), .DROP_ON_FULL(1))
    u_drop (.clock(clock), .reset(reset), .bus(bus1));

  assign {bus0.aluout, bus0.pcout, bus0.IR_Exec, bus0.M_Data, bus0.W_Control_out,
          bus0.Mem_Control_out, bus0.NZP, bus0.sr1, bus0.sr2, bus0.dr} = in_b;
  assign {bus1.aluout, bus1.pcout, bus1.IR_Exec, bus1.M_Data, bus1.W_Control_out,
          bus1.Mem_Control_out, bus1.NZP, bus1.sr1, bus1.sr2, bus1.dr} = in_b;
  assign bus0.enable_execute = enable;
  assign bus1.enable_execute = enable;
  assign bus0.out_ready      = out_ready;
  assign bus1.out_ready      = out_ready;

  assign head0 = {bus0.q_aluout, bus0.q_pcout, bus0.q_IR_Exec, bus0.q_M_Data,
                  bus0.q_W_Control_out, bus0.q_Mem_Control_out, bus0.q_NZP,
                  bus0.q_sr1, bus0.q_sr2, bus0.q_dr};
  assign head1 = {bus1.q_aluout, bus1.q_pcout, bus1.q_IR_Exec, bus1.q_M_Data,
                  bus1.q_W_Control_out, bus1.q_Mem_Control_out, bus1.q_NZP,
                  bus1.q_sr1, bus1.q_sr2, bus1.q_dr};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bundle_t rand_bundle(input logic [15:0] ir);
    bundle_t b;
    b     = bundle_t'({$urandom, $urandom, $urandom});
    b.ir  = ir;
    return b;
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic step(input bit rst, input bit en, input bundle_t b, input bit rdy);
    bit popped;
    bit was_full;
    reset = rst; enable = en; in_b = b; out_ready = rdy;
    @(posedge clock);
    if (rst) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      popped   = (mq.size() != 0) && rdy;
      was_full = (mq.size() == DEPTH);
      if (popped) void'(mq.pop_front());
      if (en) begin
        if (!was_full || popped) mq.push_back(b);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
    #1;
    reset = 1'b0; enable = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    n_checks++;
    if (bus0.count !== 3'd0 || bus1.count !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d/%0d expected 0", bus0.count, bus1.count);
    end
    n_checks++;
    if ({bus0.out_valid, bus1.out_valid, bus0.stall, bus1.stall, bus0.overflow, bus1.overflow} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got valid=%b%b stall=%b%b ovf=%b%b expected all 0",
                         bus0.out_valid, bus1.out_valid, bus0.stall, bus1.stall, bus0.overflow, bus1.overflow);
    end
    n_checks++;
    if (head0 !== '0 || head1 !== '0 || bus0.drop_count !== 8'd0 || bus1.drop_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_head: got %h/%h drops=%0d/%0d expected zeros",
                         head0, head1, bus0.drop_count, bus1.drop_count);
    end
  endtask

  task automatic test_single_pass();
    bundle_t b;
    b     = rand_bundle(16'h0);
    b.alu = 16'h1234; b.d = 3'd5; b.nzp = 3'b010;
    step(1'b0, 1'b1, b, 1'b0);
    n_checks++;
    if (bus0.out_valid !== 1'b1 || bus0.q_aluout !== 16'h1234 || bus0.q_dr !== 3'd5 ||
        bus0.q_NZP !== 3'b010 || bus0.count !== 3'd1 || head0 !== b || head1 !== b) begin
      n_fail++; $display("FAIL single_push: got valid=%b alu=%h dr=%0d count=%0d head=%h expected 1 1234 5 1 %h",
                         bus0.out_valid, bus0.q_aluout, bus0.q_dr, bus0.count, head0, b);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (bus0.out_valid !== 1'b0 || head0 !== '0 || bus0.count !== 3'd0 || bus1.count !== 3'd0) begin
      n_fail++; $display("FAIL single_pop: got valid=%b head=%h count=%0d expected 0 0 0",
                         bus0.out_valid, head0, bus0.count);
    end
  endtask

  task automatic test_fill_stall();
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, rand_bundle(16'(i)), 1'b0);
    n_checks++;
    if (bus0.count !== 3'd4 || bus0.stall !== 1'b1 || bus1.stall !== 1'b0) begin
      n_fail++; $display("FAIL fill_stall: got count=%0d stall=%b/%b expected 4 1/0",
                         bus0.count, bus0.stall, bus1.stall);
    end
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (bus0.q_IR_Exec !== 16'(i) || head0 !== mq[0] || head1 !== mq[0]) begin
        n_fail++; $display("FAIL fill_order: got ir=%0d expected %0d", bus0.q_IR_Exec, i);
      end
      step(1'b0, 1'b0, '0, 1'b1);
      if (i == 1) begin
        n_checks++;
        if (bus0.stall !== 1'b0 || bus0.count !== 3'd3) begin
          n_fail++; $display("FAIL stall_release: got stall=%b count=%0d expected 0 3", bus0.stall, bus0.count);
        end
      end
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, rand_bundle(16'(i)), 1'b0);
    step(1'b0, 1'b1, rand_bundle(16'd5), 1'b1);
    n_checks++;
    if (bus0.count !== 3'd4 || bus1.count !== 3'd4 || bus0.overflow !== 1'b0 || bus1.overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_pushpop: got count=%0d/%0d ovf=%b/%b expected 4 0",
                         bus0.count, bus1.count, bus0.overflow, bus1.overflow);
    end
    for (int i = 2; i <= 5; i++) begin
      n_checks++;
      if (bus0.q_IR_Exec !== 16'(i) || bus1.q_IR_Exec !== 16'(i) || head0 !== mq[0]) begin
        n_fail++; $display("FAIL full_pushpop_order: got ir=%0d/%0d expected %0d",
                           bus0.q_IR_Exec, bus1.q_IR_Exec, i);
      end
      step(1'b0, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_drop();
    bit stall_seen;
    stall_seen = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b1, rand_bundle(16'(i)), 1'b0);
      stall_seen |= bus1.stall;
    end
    n_checks++;
    if (stall_seen !== 1'b0 || bus1.overflow !== 1'b1 || bus1.drop_count !== 8'd2 ||
        bus0.drop_count !== 8'd2 || bus1.count !== 3'd4) begin
      n_fail++; $display("FAIL drop_account: got stall_seen=%b ovf=%b drops=%0d/%0d count=%0d expected 0 1 2/2 4",
                         stall_seen, bus1.overflow, bus1.drop_count, bus0.drop_count, bus1.count);
    end
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (bus1.q_IR_Exec !== 16'(i) || bus0.q_IR_Exec !== 16'(i)) begin
        n_fail++; $display("FAIL drop_order: got ir=%0d/%0d expected %0d", bus1.q_IR_Exec, bus0.q_IR_Exec, i);
      end
      step(1'b0, 1'b0, '0, 1'b1);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rand_bundle(16'(i)), 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, rand_bundle(16'hFFFF), 1'b0);
    n_checks++;
    if (bus1.drop_count !== 8'd255 || bus0.drop_count !== 8'd255 || m_drops != 255) begin
      n_fail++; $display("FAIL drop_saturate: got %0d/%0d expected 255", bus1.drop_count, bus0.drop_count);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, rand_bundle(16'd0), 1'b0);
    for (int i = 1; i <= 10; i++) begin
      n_checks++;
      if (bus0.q_IR_Exec !== 16'(i - 1) || bus1.q_IR_Exec !== 16'(i - 1) || head0 !== mq[0]) begin
        n_fail++; $display("FAIL wrap_order: got ir=%0d/%0d expected %0d", bus0.q_IR_Exec, bus1.q_IR_Exec, i - 1);
      end
      step(1'b0, (i < 10), rand_bundle(16'(i)), 1'b1);
    end
    n_checks++;
    if (bus0.count !== 3'd0 || bus0.overflow !== 1'b0 || bus1.overflow !== 1'b0) begin
      n_fail++; $display("FAIL wrap_end: got count=%0d ovf=%b/%b expected 0 0", bus0.count, bus0.overflow, bus1.overflow);
    end
  endtask

  task automatic test_reset_mid();
    bundle_t b;
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, rand_bundle(16'(i)), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (bus0.count !== 3'd3 || bus0.overflow !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: got count=%0d ovf=%b expected 3 1", bus0.count, bus0.overflow);
    end
    step(1'b1, 1'b1, rand_bundle(16'h00AA), 1'b1);
    n_checks++;
    if (bus0.count !== 3'd0 || bus0.out_valid !== 1'b0 || bus0.overflow !== 1'b0 ||
        bus0.drop_count !== 8'd0 || bus1.count !== 3'd0 || bus1.overflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got count=%0d valid=%b ovf=%b drops=%0d expected 0 0 0 0",
                         bus0.count, bus0.out_valid, bus0.overflow, bus0.drop_count);
    end
    b = rand_bundle(16'h0BEE);
    step(1'b0, 1'b1, b, 1'b0);
    n_checks++;
    if (head0 !== b || head1 !== b || bus0.count !== 3'd1) begin
      n_fail++; $display("FAIL mid_first_push: got head=%h count=%0d expected %h 1", head0, bus0.count, b);
    end
  endtask

  task automatic test_random();
    bundle_t exp_head;
    step(1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < 400; c++) begin
      step(1'b0, ($urandom_range(0, 3) != 0), rand_bundle(16'($urandom)), 1'($urandom_range(0, 1)));
      exp_head = (mq.size() != 0) ? mq[0] : '0;
      n_checks++;
      if (head0 !== exp_head || head1 !== exp_head) begin
        n_fail++; $display("FAIL rand_head cyc %0d: got %h/%h expected %h", c, head0, head1, exp_head);
      end
      n_checks++;
      if (bus0.count !== CW'(mq.size()) || bus1.count !== CW'(mq.size()) ||
          bus0.out_valid !== (mq.size() != 0) || bus1.out_valid !== (mq.size() != 0)) begin
        n_fail++; $display("FAIL rand_count cyc %0d: got %0d/%0d expected %0d", c, bus0.count, bus1.count, mq.size());
      end
      n_checks++;
      if (bus0.stall !== (mq.size() == DEPTH) || bus1.stall !== 1'b0 ||
          bus0.overflow !== m_ovf || bus1.overflow !== m_ovf ||
          bus0.drop_count !== 8'(m_drops) || bus1.drop_count !== 8'(m_drops)) begin
        n_fail++; $display("FAIL rand_status cyc %0d: got stall=%b/%b ovf=%b drops=%0d expected %b/0 %b %0d",
                           c, bus0.stall, bus1.stall, bus0.overflow, bus0.drop_count,
                           (mq.size() == DEPTH), m_ovf, m_drops);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; in_b = '0;
    m_ovf = 1'b0; m_drops = 0;
    test_reset();
    test_single_pass();
    test_fill_stall();
    test_full_push_pop();
    test_drop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
